// File: rtl/key_priority_encoder.sv
// key_priority_encoder: synchronized, debounced 8-key priority encoder
// with a valid/ack handshake and a single report per debounced press.
module key_priority_encoder #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ei_n,
   input  logic [7:0] keys_n,
   input  logic       ack,
   output logic [2:0] code,
   output logic       valid,
   output logic       gs
);

   localparam int CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEB,
      S_HOLD,
      S_REL
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_sync1;
   logic [7:0]    r_sync2;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [2:0]    r_cand;
   logic [2:0]    w_cand_nxt;
   logic [2:0]    r_code;
   logic [2:0]    w_code_nxt;
   logic          r_valid;
   logic          w_valid_nxt;
   logic          r_gs;
   logic          w_any;
   logic [2:0]    w_enc;

   assign w_any = (r_sync2 != 8'hFF);
   assign code  = r_code;
   assign valid = r_valid;
   assign gs    = r_gs;

   // Two-flop synchronizer; idle level of a key line is 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 8'hFF;
         r_sync2 <= 8'hFF;
      end else begin
         r_sync1 <= keys_n;
         r_sync2 <= r_sync1;
      end
   end

   // Highest-numbered low key wins; later iterations override earlier.
   always_comb begin
      w_enc = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (!r_sync2[i]) begin
            w_enc = 3'(i);
         end
      end
   end

   // Group select tracks synchronized keys and enable in every state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gs <= 1'b0;
      end else begin
         r_gs <= w_any & ~ei_n;
      end
   end

   // State, counter, candidate and report registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_cand  <= 3'd0;
         r_code  <= 3'd0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cand  <= w_cand_nxt;
         r_code  <= w_code_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   // Next-state: debounce a press, hold until ack, debounce the release.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_code_nxt  = r_code;
      w_valid_nxt = r_valid;
      unique case (r_state)
         S_IDLE: begin
            if (w_any && !ei_n) begin
               w_cand_nxt  = w_enc;
               w_cnt_nxt   = '0;
               w_state_nxt = S_DEB;
            end
         end
         S_DEB: begin
            if (ei_n || !w_any || (w_enc != r_cand)) begin
               w_state_nxt = S_IDLE;
            end else if (r_cnt == LAST) begin
               w_code_nxt  = r_cand;
               w_valid_nxt = 1'b1;
               w_state_nxt = S_HOLD;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_HOLD: begin
            if (ack) begin
               w_valid_nxt = 1'b0;
               w_cnt_nxt   = '0;
               w_state_nxt = S_REL;
            end
         end
         S_REL: begin
            if (w_any) begin
               w_cnt_nxt = '0;
            end else if (r_cnt == LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_key_priority_encoder.sv
// tb_key_priority_encoder: directed and random stimulus checked against
// a press/hold/release reference model of the key encoder.
module tb_key_priority_encoder;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ei_n = 1'b0;
   logic [7:0] keys_n = 8'hFF;
   logic       ack = 1'b0;
   logic [2:0] code;
   logic       valid;
   logic       gs;

   int nchk = 0;
   int npass = 0;

   // reference model
   logic [7:0] m_s1, m_s2;
   int         m_mode;
   int         m_run;
   int         m_rel;
   logic [2:0] m_cand, m_code;
   logic       m_valid, m_gs;

   key_priority_encoder #(.DEBOUNCE_CYCLES(D)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ei_n   (ei_n),
      .keys_n (keys_n),
      .ack    (ack),
      .code   (code),
      .valid  (valid),
      .gs     (gs)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic int enc(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) begin
         if (!v[i]) return i;
      end
      return 0;
   endfunction

   task automatic model_reset();
      m_s1 = 8'hFF;
      m_s2 = 8'hFF;
      m_mode = 0;
      m_run = 0;
      m_rel = 0;
      m_cand = 3'd0;
      m_code = 3'd0;
      m_valid = 1'b0;
      m_gs = 1'b0;
   endtask

   // mode 0: waiting for a press (m_run = stable edges seen so far)
   // mode 1: reported, waiting for ack; mode 2: waiting for release
   task automatic model_edge();
      logic [7:0] sk;
      bit         any, cond;
      sk = m_s2;
      any = (sk != 8'hFF);
      cond = any && !ei_n;
      m_gs = cond;
      case (m_mode)
         0: begin
            if (m_run == 0) begin
               if (cond) begin
                  m_run = 1;
                  m_cand = 3'(enc(sk));
               end
            end else if (cond && enc(sk) == int'(m_cand)) begin
               m_run++;
               if (m_run == D + 1) begin
                  m_code = m_cand;
                  m_valid = 1'b1;
                  m_mode = 1;
                  m_run = 0;
               end
            end else begin
               m_run = 0;
            end
         end
         1: begin
            if (ack) begin
               m_valid = 1'b0;
               m_mode = 2;
               m_rel = 0;
            end
         end
         default: begin
            if (!any) begin
               m_rel++;
               if (m_rel == D) m_mode = 0;
            end else begin
               m_rel = 0;
            end
         end
      endcase
      m_s2 = m_s1;
      m_s1 = keys_n;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_model();
      chk("code", {5'd0, code}, {5'd0, m_code});
      chk("valid", {7'd0, valid}, {7'd0, m_valid});
      chk("gs", {7'd0, gs}, {7'd0, m_gs});
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_model();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_ack();
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   initial begin
      int hold;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_code", {5'd0, code}, 8'd0);
      chk("rst_valid", {7'd0, valid}, 8'd0);
      chk("rst_gs", {7'd0, gs}, 8'd0);
      rst_n = 1'b1;
      steps(3);

      // single key 5
      keys_n = 8'b1101_1111;
      steps(6);
      chk("single_e5_valid", {7'd0, valid}, 8'd0);
      step();
      chk("single_e6_valid", {7'd0, valid}, 8'd1);
      chk("single_e6_code", {5'd0, code}, 8'd5);
      steps(10);
      chk("single_held_valid", {7'd0, valid}, 8'd1);
      do_ack();
      chk("single_ack_valid", {7'd0, valid}, 8'd0);
      chk("single_ack_code", {5'd0, code}, 8'd5);
      steps(20);
      chk("single_norepeat", {7'd0, valid}, 8'd0);
      keys_n = 8'hFF;
      steps(10);

      // priority: keys 6 and 2, then 2 alone
      keys_n = 8'b1011_1011;
      steps(7);
      chk("prio_code", {5'd0, code}, 8'd6);
      chk("prio_valid", {7'd0, valid}, 8'd1);
      do_ack();
      keys_n = 8'hFF;
      steps(10);
      keys_n = 8'b1111_1011;
      steps(10);
      chk("prio2_code", {5'd0, code}, 8'd2);
      do_ack();
      keys_n = 8'hFF;
      steps(10);

      // bounce on key 3
      for (int r = 0; r < 3; r++) begin
         keys_n = 8'b1111_0111;
         steps(2);
         keys_n = 8'hFF;
         steps(2);
      end
      steps(10);
      chk("bounce_valid", {7'd0, valid}, 8'd0);

      // candidate change: key 1 then key 7
      keys_n = 8'b1111_1101;
      steps(2);
      keys_n = 8'b0111_1101;
      steps(12);
      chk("cand_code", {5'd0, code}, 8'd7);
      chk("cand_valid", {7'd0, valid}, 8'd1);
      do_ack();
      keys_n = 8'hFF;
      steps(10);

      // enable held off with key 4 pressed
      ei_n = 1'b1;
      keys_n = 8'b1110_1111;
      steps(20);
      chk("en_off_valid", {7'd0, valid}, 8'd0);
      chk("en_off_gs", {7'd0, gs}, 8'd0);
      ei_n = 1'b0;
      steps(D + 3);
      chk("en_on_gs", {7'd0, gs}, 8'd1);
      chk("en_on_code", {5'd0, code}, 8'd4);
      chk("en_on_valid", {7'd0, valid}, 8'd1);
      do_ack();
      keys_n = 8'hFF;
      steps(10);

      // asynchronous reset while holding a report of key 5
      keys_n = 8'b1101_1111;
      steps(8);
      chk("ar_pre_valid", {7'd0, valid}, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("ar_valid", {7'd0, valid}, 8'd0);
      chk("ar_code", {5'd0, code}, 8'd0);
      chk("ar_gs", {7'd0, gs}, 8'd0);
      #1;
      rst_n = 1'b1;
      steps(10);
      chk("ar_fresh_code", {5'd0, code}, 8'd5);
      chk("ar_fresh_valid", {7'd0, valid}, 8'd1);
      do_ack();
      keys_n = 8'hFF;
      steps(10);

      // random segments of keys, enable and ack
      for (int s = 0; s < 400; s++) begin
         if ($urandom_range(0, 3) == 0) keys_n = 8'hFF;
         else keys_n = 8'($urandom);
         ei_n = ($urandom_range(0, 5) == 0);
         hold = $urandom_range(1, 12);
         for (int c = 0; c < hold; c++) begin
            ack = ($urandom_range(0, 2) == 0);
            step();
         end
      end
      ack = 1'b0;

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule

// File: doc/key_priority_encoder.md
# key_priority_encoder

Sequential 8-input priority encoder, the encoding counterpart to the 3-to-8 decoder used to build our combinational adders. It synchronizes and debounces eight active-low key lines and encodes the highest-numbered pressed key into a 3-bit binary code with a valid/ack handshake. It replaces raw switch wiring at the front of the adder and decoder experiments, where it drives the `{a,b,cin}`-style 3-bit operand fields.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a press or a release. Legal range is 1 to 255.
- `clk` input, 1 bit: sole clock, rising-edge active.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `ei_n` input, 1 bit: enable input, active-low, 74LS148 semantics. When 1, new presses are not accepted.
- `keys_n` input, 8 bits: key lines, active-low. Bit 7 has the highest priority. These lines are asynchronous to `clk`.
- `ack` input, 1 bit: consumer acknowledge, sampled only while `valid` = 1.
- `code` output, 3 bits: binary index of the accepted key, active-high.
- `valid` output, 1 bit: `code` is valid. Held high until acknowledged.
- `gs` output, 1 bit: group select, registered. Equals (any synchronized key low) AND (`ei_n` = 0).

## Operation
- **Synchronizer:** 2-flop synchronizer per key line. All flops reset to 1. `sk` denotes the synchronized key vector.
- **Priority function:** `enc(sk)` is the index of the highest bit of `sk` that equals 0. `any` = (`sk` != 8'hFF).
- **Debounce counter:** `cnt` has width max(1, clog2(DEBOUNCE_CYCLES)).
- **IDLE:**
  - If `any` and `ei_n` = 0: `cand <= enc(sk)`, `cnt <= 0`, go to DEBOUNCE.
  - Otherwise stay in IDLE.
- **DEBOUNCE:**
  - If `ei_n` = 1, or !`any`, or `enc(sk)` != `cand`: go to IDLE. No output change.
  - Else if `cnt` = DEBOUNCE_CYCLES-1: `code <= cand`, `valid <= 1`, go to HOLD.
  - Else `cnt <= cnt+1`.
- **HOLD:**
  - If `ack` = 1: `valid <= 0`, `cnt <= 0`, go to RELEASE. `code` keeps its value.
  - `ei_n` and key changes are ignored in this state.
- **RELEASE:**
  - If !`any`: when `cnt` = DEBOUNCE_CYCLES-1, go to IDLE; otherwise `cnt <= cnt+1`.
  - If `any`: `cnt <= 0`.
  - `ei_n` is ignored in this state.
- **Single report per press:** a key held after `ack` produces no second `valid` until a full debounced release has occurred.
- **Multiple keys:** only the highest pressed key is reported. Pressing a higher key during DEBOUNCE changes `enc` and aborts to IDLE; the next IDLE pass restarts debounce with the new candidate.
- **`gs`:** updated every cycle from `sk` and `ei_n`, in all states.
- **Reset values:**
  - State IDLE; `cnt` = 0; `cand` = 0.
  - `code` = 3'd0, `valid` = 0, `gs` = 0.
  - Synchronizer flops = 1.
- **Reset mid-operation:** assertion of `rst_n` forces all reset values immediately, without waiting for a clock edge. A pending report is discarded.

## Timing
- **Edge numbering:** edge 0 is the first rising edge at which the stable press is captured by the first synchronizer flop.
- **Press sequence:**
  - `sk` reflects the press after edge 1.
  - IDLE moves to DEBOUNCE at edge 2.
  - `valid` and `code` are updated at edge DEBOUNCE_CYCLES+2. With the default of 4, that is edge 6; with DEBOUNCE_CYCLES = 1, edge 3.
- **Bounce rejection:** a press shorter than DEBOUNCE_CYCLES+1 synchronized cycles never raises `valid`.
- **Acknowledge:**
  - `ack` is honoured only in cycles where `valid` is already 1. If `ack` is high at the same edge `valid` rises, it is ignored.
  - `valid` falls at the edge that samples `ack` = 1.
  - Holding `ack` high continuously causes no effect outside HOLD.
- **Release:** RELEASE returns to IDLE DEBOUNCE_CYCLES edges after the first edge at which `sk` = 8'hFF, provided no bounce occurs.
- **`gs`:** lags `keys_n` by 3 edges (2 synchronizer stages plus 1 output register).

## Test plan
- **Single key:** DEBOUNCE_CYCLES = 4; hold `keys_n` = 8'b1101_1111 from before edge 0.
  - Expected: `code` = 5 and `valid` = 1 after edge 6; `valid` stays high for 10 idle cycles.
  - Then `ack` = 1 for one cycle → `valid` = 0 at the next edge, `code` still 5.
  - Key still held → no new `valid`.
- **Priority:** `keys_n` = 8'b1011_1011 (keys 6 and 2).
  - Expected: `code` = 6, `valid` = 1 after edge 6.
  - After ack and release, press key 2 alone → `code` = 2.
- **Bounce:** key 3 low for 2 cycles, then high, repeated 3 times, then stable high.
  - Expected: `valid` never rises; state returns to IDLE.
- **Candidate change:** press key 1; two cycles later, additionally press key 7.
  - Expected: key 1 is never reported; `code` = 7 is reported D+2 edges after key 7 reaches `sk` plus the IDLE re-entry.
- **Enable:** `ei_n` = 1 with key 4 pressed for 20 cycles.
  - Expected: `valid` = 0 and `gs` = 0 throughout.
  - Drop `ei_n` to 0 → `gs` = 1 and `code` = 4, `valid` = 1 within D+3 edges.
- **Async reset:** assert `rst_n` = 0 mid-clock while in HOLD with `code` = 5.
  - Expected: `valid` = 0, `code` = 0, `gs` = 0 before the next edge.
  - After release of reset with the key still held, a fresh report of `code` = 5 occurs.
